// File: rtl/ysyx_25020037_ifu_fetch.sv
// Instruction fetch: one AXI4-Lite read per instruction, result held until decode accepts.
// Latency: AR handshake to ifu_valid is 2 cycles minimum; decode backpressure parks the FSM in HOLD.
module ysyx_25020037_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idu_ready,
  output logic        ifu_valid,
  output logic [63:0] fu_to_du_bus,
  output logic        ifu_fault,
  input  logic        exu_dnpc_valid,
  input  logic [31:0] exu_dnpc,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_valid, w_valid_nxt;
  logic [63:0] r_bus, w_bus_nxt;
  logic        r_fault, w_fault_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
      r_drop   <= 1'b0;
      r_valid  <= 1'b0;
      r_bus    <= 64'd0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
      r_drop   <= w_drop_nxt;
      r_valid  <= w_valid_nxt;
      r_bus    <= w_bus_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_target_nxt = exu_dnpc_valid ? exu_dnpc : r_target;
    w_drop_nxt   = r_drop;
    w_valid_nxt  = r_valid;
    w_bus_nxt    = r_bus;
    w_fault_nxt  = r_fault;
    case (r_state)
      S_REQ: begin
        // The AR cannot be withdrawn, so a redirect here only marks its data stale.
        if (exu_dnpc_valid) w_drop_nxt = 1'b1;
        if (arready)        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (exu_dnpc_valid) w_drop_nxt = 1'b1;
        if (rvalid) begin
          if (r_drop || exu_dnpc_valid) begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = w_target_nxt;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_HOLD;
            w_valid_nxt = 1'b1;
            w_bus_nxt   = {r_pc, rdata};
            w_fault_nxt = |rresp;
          end
        end
      end
      S_HOLD: begin
        // Redirect beats a same-cycle accept: decode discards the instruction itself.
        if (exu_dnpc_valid) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = exu_dnpc;
          w_valid_nxt = 1'b0;
        end else if (idu_ready) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = r_pc + 32'd4;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign araddr       = r_pc;
  assign arvalid      = (r_state == S_REQ);
  assign rready       = (r_state == S_WAIT);
  assign ifu_valid    = r_valid;
  assign fu_to_du_bus = r_bus;
  assign ifu_fault    = r_fault;

endmodule

// File: tb/tb_ysyx_25020037_ifu_fetch.sv
// Randomized bench for the fetch stage: a latency-randomized AXI memory plus a
// transaction-level model of which address is fetched next and what decode sees.
module tb_ysyx_25020037_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int P_ADDR  = 0;
  localparam int P_DATA  = 1;
  localparam int P_DELIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        idu_ready;
  logic        ifu_valid;
  logic [63:0] fu_to_du_bus;
  logic        ifu_fault;
  logic        exu_dnpc_valid;
  logic [31:0] exu_dnpc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  ysyx_25020037_ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .idu_ready(idu_ready), .ifu_valid(ifu_valid),
    .fu_to_du_bus(fu_to_du_bus), .ifu_fault(ifu_fault),
    .exu_dnpc_valid(exu_dnpc_valid), .exu_dnpc(exu_dnpc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // memory environment
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          g_dmin, g_dmax, g_ar_pct;
  bit          g_ar_block;

  // transaction-level model: the fetch in progress and whether a redirect killed it
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_kill;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic bit flt_of(input logic [31:0] a);
    return (a[5:2] == 4'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    case (m_phase)
      P_ADDR: begin
        chk("arvalid_req", {63'd0, arvalid}, 64'd1);
        chk("araddr", {32'd0, araddr}, {32'd0, m_pc});
        chk("rready_req", {63'd0, rready}, 64'd0);
        chk("valid_req", {63'd0, ifu_valid}, 64'd0);
      end
      P_DATA: begin
        chk("arvalid_wait", {63'd0, arvalid}, 64'd0);
        chk("rready_wait", {63'd0, rready}, 64'd1);
        chk("valid_wait", {63'd0, ifu_valid}, 64'd0);
      end
      default: begin
        chk("valid_hold", {63'd0, ifu_valid}, 64'd1);
        chk("bus_hold", fu_to_du_bus, {m_pc, inst_of(m_pc)});
        chk("fault_hold", {63'd0, ifu_fault}, {63'd0, flt_of(m_pc)});
        chk("arvalid_hold", {63'd0, arvalid}, 64'd0);
        chk("rready_hold", {63'd0, rready}, 64'd0);
      end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idu_ready = 1'b0; exu_dnpc_valid = 1'b0; exu_dnpc = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    m_phase = P_ADDR; m_pc = RST_PC; m_tgt = RST_PC; m_kill = 1'b0;
    chk("rst_arvalid", {63'd0, arvalid}, 64'd1);
    chk("rst_araddr", {32'd0, araddr}, {32'd0, RST_PC});
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("rst_valid", {63'd0, ifu_valid}, 64'd0);
    chk("rst_bus", fu_to_du_bus, 64'd0);
    chk("rst_fault", {63'd0, ifu_fault}, 64'd0);
  endtask

  // One clock: drive at negedge, advance model/memory at posedge, check at next negedge.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    bit          ar_hs_m, r_hs_m, mem_ar_hs, mem_r_hs;
    logic [31:0] addr_s;
    idu_ready      = rdy;
    exu_dnpc_valid = rv;
    exu_dnpc       = rv ? tgt : 32'h1234_5670;
    arready = !mem_busy && !g_ar_block && ($urandom_range(0, 99) < g_ar_pct);
    rvalid  = mem_busy && (mem_cnt == 0);
    rdata   = rvalid ? inst_of(mem_addr) : 32'hDEAD_BEEF;
    rresp   = (rvalid && flt_of(mem_addr)) ? 2'b10 : 2'b00;
    mem_ar_hs = arvalid && arready;
    mem_r_hs  = rvalid && rready;
    addr_s    = araddr;
    ar_hs_m   = (m_phase == P_ADDR) && arready;
    r_hs_m    = (m_phase == P_DATA) && rvalid;
    @(posedge clk);
    if (mem_r_hs) mem_busy = 1'b0;
    if (mem_ar_hs) begin
      mem_busy = 1'b1;
      mem_addr = addr_s;
      mem_cnt  = $urandom_range(g_dmax, g_dmin);
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    case (m_phase)
      P_ADDR: begin
        if (rv) begin m_kill = 1'b1; m_tgt = tgt; end
        if (ar_hs_m) m_phase = P_DATA;
      end
      P_DATA: begin
        if (rv) begin m_kill = 1'b1; m_tgt = tgt; end
        if (r_hs_m) begin
          if (m_kill) begin
            m_pc = m_tgt; m_kill = 1'b0; m_phase = P_ADDR;
          end else begin
            m_phase = P_DELIV;
          end
        end
      end
      default: begin
        if (rv) begin
          m_pc = tgt; m_tgt = tgt; m_phase = P_ADDR;
        end else if (rdy) begin
          m_pc = m_pc + 32'd4; m_phase = P_ADDR;
        end
      end
    endcase
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 40; i++) begin
      if (m_phase == p) return;
      cycle(1'b1, 1'b0, 32'd0);
    end
    if (m_phase != p) chk("phase_timeout", m_phase, p);
  endtask

  logic [63:0] saved_bus;

  initial begin
    g_dmin = 0; g_dmax = 0; g_ar_pct = 100; g_ar_block = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // zero-wait sequential fetch, including the faulting word at 8000_0004
    wait_phase(P_DELIV);
    chk("seq0_pc", {32'd0, fu_to_du_bus[63:32]}, 64'h8000_0000);
    cycle(1'b1, 1'b0, 32'd0);
    chk("seq1_addr", {32'd0, araddr}, 64'h8000_0004);
    wait_phase(P_DELIV);
    chk("flt_pc", {32'd0, fu_to_du_bus[63:32]}, 64'h8000_0004);
    chk("flt_set", {63'd0, ifu_fault}, 64'd1);
    cycle(1'b1, 1'b0, 32'd0);
    chk("seq2_addr", {32'd0, araddr}, 64'h8000_0008);
    wait_phase(P_DELIV);
    chk("flt_clear", {63'd0, ifu_fault}, 64'd0);

    // decode stalls five cycles
    saved_bus = fu_to_du_bus;
    repeat (5) cycle(1'b0, 1'b0, 32'd0);
    chk("stall_bus", fu_to_du_bus, saved_bus);
    cycle(1'b1, 1'b0, 32'd0);
    chk("stall_next", {32'd0, araddr}, {32'd0, saved_bus[63:32] + 32'd4});

    // redirect while waiting on slow data
    g_dmin = 3; g_dmax = 3;
    wait_phase(P_DATA);
    cycle(1'b1, 1'b1, 32'h8000_0100);
    wait_phase(P_ADDR);
    chk("redir_wait", {32'd0, araddr}, 64'h8000_0100);
    g_dmin = 0; g_dmax = 0;

    // redirect in HOLD with decode accepting in the same cycle
    wait_phase(P_DELIV);
    cycle(1'b1, 1'b1, 32'h8000_0200);
    chk("redir_hold_v", {63'd0, ifu_valid}, 64'd0);
    chk("redir_hold_a", {32'd0, araddr}, 64'h8000_0200);

    // PC wrap at the top of the address space
    wait_phase(P_DELIV);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_phase(P_DELIV);
    chk("wrap_pc", {32'd0, fu_to_du_bus[63:32]}, 64'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'd0);
    chk("wrap_addr", {32'd0, araddr}, 64'd0);

    // AR stalled, then reset mid-request
    g_ar_block = 1'b1;
    wait_phase(P_ADDR);
    saved_bus = {32'd0, araddr};
    repeat (4) cycle(1'b1, 1'b0, 32'd0);
    chk("stall_addr", {32'd0, araddr}, saved_bus);
    do_reset();
    g_ar_block = 1'b0;

    // randomized traffic
    g_dmin = 0; g_dmax = 3; g_ar_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = 32'h8000_0000 + (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFFC;
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, t);
      if (i == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
